// File: rtl/score_display.sv
// Binary score to 4-digit BCD via an iterative double-dabble FSM, driving a
// time-multiplexed, active-low 7-segment display with optional leading-zero blanking.
module score_display #(
  parameter logic [15:0] CLK_DIV  = 16'd50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  output logic [15:0] bcd,
  output logic        overflow,
  output logic        busy,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  state_e      state_q, state_d;
  logic [15:0] last_q, last_d;
  logic [15:0] shreg_q, shreg_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [19:0] adj;

  // One double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    adj     = add3(acc_q);
    case (state_q)
      IDLE: begin
        if (score != last_q) begin
          shreg_d = score;
          last_d  = score;
          acc_d   = 20'd0;
          iter_d  = 4'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        {acc_d, shreg_d} = {adj, shreg_q} << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = LOAD;
      end
      LOAD: begin
        if (acc_q[19:16] != 4'd0 || acc_q[15:0] > 16'h9999) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = acc_q[15:0];
          ovf_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 16'd0;
      shreg_q <= 16'd0;
      acc_q   <= 20'd0;
      iter_q  <= 4'd0;
      bcd_q   <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);

  // Scan: an/seg are registered from the next digit index so both switch on one edge.
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  nib;
  logic        blank;
  logic        tc;

  function automatic logic [7:0] seg_map(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    tc    = (cnt_q == CLK_DIV - 16'd1);
    cnt_d = tc ? 16'd0 : cnt_q + 16'd1;
    idx_d = tc ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_d);
    nib   = 4'd0;
    blank = 1'b0;
    case (idx_d)
      2'd0: begin nib = bcd_q[3:0];   blank = 1'b0; end
      2'd1: begin nib = bcd_q[7:4];   blank = BLANK_LZ && (bcd_q[15:4]  == 12'd0); end
      2'd2: begin nib = bcd_q[11:8];  blank = BLANK_LZ && (bcd_q[15:8]  == 8'd0);  end
      default: begin nib = bcd_q[15:12]; blank = BLANK_LZ && (bcd_q[15:12] == 4'd0); end
    endcase
    seg_d = blank ? 8'hFF : seg_map(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
      idx_q <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= 8'hC0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: stimulus pushes expected conversions, a monitor
// pops them on each busy falling edge; the scan is checked against a digit-level model.
module tb_score_display;
  localparam logic [15:0] CD = 16'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] score = 16'd0;
  logic [15:0] bcd;
  logic        overflow, busy;
  logic [3:0]  an;
  logic [7:0]  seg;

  score_display #(.CLK_DIV(CD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .score(score), .bcd(bcd),
    .overflow(overflow), .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [16:0] expq[$];
  int          model_last = 0;
  logic [15:0] disp = 16'd0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Reference: decimal digits by plain arithmetic, saturating at 9999.
  function automatic logic [16:0] ref_conv(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] ref_seg(input logic [15:0] d, input int i);
    logic [7:0] tbl [10];
    logic [3:0] n;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (i > 0 && (d >> (4 * i)) == 16'd0) return 8'hFF;
    n = d[4*i +: 4];
    return (n < 10) ? tbl[n] : 8'hFF;
  endfunction

  // Monitor: each busy 1->0 outside reset is a completed conversion.
  initial begin : mon
    bit          pb;
    int          bc;
    logic [16:0] e;
    pb = 1'b0;
    bc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pb = 1'b0;
        bc = 0;
      end else begin
        if (busy) bc++;
        else if (pb) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_conv: got bcd=%0h ovf=%0b want no conversion", bcd, overflow);
          end else begin
            e = expq.pop_front();
            chk("bcd", bcd, e[15:0]);
            chk("ovf", overflow, e[16]);
            chk("busy_len", bc, 17);
          end
          bc = 0;
        end
        pb = busy;
      end
    end
  end

  task automatic wait_busy(input logic lvl, input string nm);
    int n;
    n = 0;
    while (busy !== lvl && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s timeout: busy=%0b want %0b", nm, busy, lvl);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    wait_busy(1'b0, "settle");
    repeat (3) @(negedge clk);
  endtask

  task automatic apply(input int v);
    logic [16:0] r;
    if (v != model_last) begin
      expq.push_back(ref_conv(v));
      model_last = v;
    end
    r = ref_conv(model_last);
    disp = r[15:0];
    score = 16'(v);
    settle();
  endtask

  task automatic scan_check();
    logic [3:0] pa, m;
    int run, ix;
    bit first;
    @(negedge clk);
    pa = an;
    run = 1;
    first = 1'b1;
    for (int k = 0; k < 5 * int'(CD); k++) begin
      ix = -1;
      for (int i = 0; i < 4; i++) begin
        m = 4'b0001 << i;
        if (an == ~m) ix = i;
      end
      total++;
      if (ix < 0 || seg !== ref_seg(disp, ix)) begin
        bad++;
        $display("FAIL scan_seg: an=%b seg=%0h want digit %0d seg=%0h", an, seg, ix,
                 (ix < 0) ? 8'hXX : ref_seg(disp, ix));
      end
      @(negedge clk);
      if (an !== pa) begin
        chk("scan_order", an, {pa[2:0], pa[3]});
        if (!first) chk("scan_period", run, int'(CD));
        first = 1'b0;
        run = 1;
        pa = an;
      end else run++;
    end
  endtask

  initial begin : stim
    int v, sel;
    logic [16:0] r;
    // T1: reset state and idle scan of zero
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 8'hC0);
    reset = 1'b0;
    disp = 16'h0000;
    settle();
    scan_check();
    // T2
    apply(1234);
    scan_check();
    // T3, T4
    apply(65535);
    apply(42);
    scan_check();
    apply(9999);
    apply(10000);
    scan_check();
    apply(10);
    // T5: change during conversion is picked up after returning to IDLE
    expq.push_back(ref_conv(5));
    expq.push_back(ref_conv(700));
    model_last = 700;
    r = ref_conv(700);
    disp = r[15:0];
    score = 16'd5;
    wait_busy(1'b1, "t5_start");
    repeat (2) @(negedge clk);
    score = 16'd700;
    wait_busy(1'b0, "t5_first_done");
    @(negedge clk);
    chk("t5_rebusy", busy, 1'b1);
    settle();
    // T6: blanking and reset mid-conversion
    apply(7);
    scan_check();
    score = 16'd4321;
    wait_busy(1'b1, "t6_start");
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_bcd", bcd, 16'h0000);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ovf", overflow, 1'b0);
    chk("t6_an", an, 4'b1110);
    chk("t6_seg", seg, 8'hC0);
    expq.delete();
    model_last = 0;
    @(negedge clk);
    apply(4321);
    reset = 1'b0;
    settle();
    scan_check();
    // Random mix: repeats, full range, decimal range, saturation boundary
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: v = model_last;
        1: v = int'($urandom & 32'hFFFF);
        2: v = $urandom_range(0, 9999);
        default: v = $urandom_range(9990, 10010);
      endcase
      apply(v);
      if (it % 6 == 5) scan_check();
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
